led_matrix_pwm: RTL

//  Parametrised multiplexed LED-matrix driver with per-pixel grayscale (PWM) and a double-buffered frame.
//  It scans DIM_Y rows one at a time and drives DIM_X column lines with per-pixel PWM.

---
 rtl/led_matrix_pwm.sv | 104 ++++++++++
 1 files changed

// File: rtl/led_matrix_pwm.sv
// led_matrix_pwm: multiplexed LED-matrix scanner with per-pixel PWM and a double-buffered frame.
// Rows are scanned one at a time with a blanking gap; new frames swap in only at a frame boundary.
module led_matrix_pwm #(
    parameter int DIM_X       = 6,
    parameter int DIM_Y       = 6,
    parameter int BPP         = 4,
    parameter int TICK_DIV    = 64,
    parameter int BLANK_TICKS = 2,
    parameter bit ROW_ACT     = 1'b1,
    parameter bit COL_ACT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIM_X*DIM_Y*BPP-1:0] frame_data,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    output logic                     frame_start,
    output logic [DIM_Y-1:0]         row,
    output logic [DIM_X-1:0]         col
);
    localparam int NS = (1 << BPP) - 1;
    localparam int SW = NS > 1 ? $clog2(NS) : 1;
    localparam int BW = BLANK_TICKS > 1 ? $clog2(BLANK_TICKS) : 1;
    localparam int RW = DIM_Y > 1 ? $clog2(DIM_Y) : 1;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int FW = DIM_X * DIM_Y * BPP;

    typedef enum logic {SCAN, BLANK} state_t;

    state_t          state;
    logic [PW-1:0]   pre;
    logic [RW-1:0]   row_idx;
    logic [SW-1:0]   slot;
    logic [BW-1:0]   blank_cnt;
    logic [FW-1:0]   display;
    logic [FW-1:0]   pending;
    logic            pending_full;
    logic            tick;
    logic            wrap;
    logic            hs;
    logic [DIM_Y-1:0] row_n;
    logic [DIM_X-1:0] col_n;

    assign tick        = pre == PW'(TICK_DIV - 1);
    assign frame_ready = ~pending_full;
    assign hs          = frame_valid & ~pending_full;
    // last blank tick of the last row: the frame boundary where buffers swap
    assign wrap        = state == BLANK && tick && blank_cnt == BW'(BLANK_TICKS - 1)
                         && row_idx == RW'(DIM_Y - 1);

    always_comb begin
        row_n = state == SCAN ? (DIM_Y'(1) << row_idx) : '0;
        row_n = ROW_ACT ? row_n : ~row_n;
        col_n = '0;
        for (int c = 0; c < DIM_X; c++) begin
            col_n[c] = (state == SCAN && BPP'(slot) < display[(int'(row_idx) * DIM_X + c) * BPP +: BPP])
                       ? COL_ACT : ~COL_ACT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre          <= '0;
            state        <= BLANK;
            row_idx      <= RW'(DIM_Y - 1);
            slot         <= '0;
            blank_cnt    <= '0;
            display      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            frame_start  <= 1'b0;
            row          <= {DIM_Y{~ROW_ACT}};
            col          <= {DIM_X{~COL_ACT}};
        end else begin
            pre          <= tick ? '0 : pre + 1'b1;
            frame_start  <= wrap;
            row          <= row_n;
            col          <= col_n;
            if (state == SCAN) begin
                if (tick) begin
                    if (slot == SW'(NS - 1)) begin
                        state     <= BLANK;
                        blank_cnt <= '0;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
            end else if (tick) begin
                if (blank_cnt == BW'(BLANK_TICKS - 1)) begin
                    state   <= SCAN;
                    slot    <= '0;
                    row_idx <= row_idx == RW'(DIM_Y - 1) ? '0 : row_idx + 1'b1;
                end else begin
                    blank_cnt <= blank_cnt + 1'b1;
                end
            end
            if (hs)
                pending <= frame_data;
            if (wrap && pending_full)
                display <= pending;
            pending_full <= hs | (pending_full & ~wrap);
        end
    end
endmodule
